// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, opcode map and IR capture pattern.
package jtag_pkg;

  typedef enum logic [3:0] {
    TAP_EX2DR = 4'h0,
    TAP_EX1DR = 4'h1,
    TAP_SHDR  = 4'h2,
    TAP_PAUDR = 4'h3,
    TAP_SELIR = 4'h4,
    TAP_UPDDR = 4'h5,
    TAP_CAPDR = 4'h6,
    TAP_SELDR = 4'h7,
    TAP_EX2IR = 4'h8,
    TAP_EX1IR = 4'h9,
    TAP_SHIR  = 4'hA,
    TAP_PAUIR = 4'hB,
    TAP_RTI   = 4'hC,
    TAP_UPDIR = 4'hD,
    TAP_CAPIR = 4'hE,
    TAP_TLR   = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_ID     = 2'd1,
    DR_BSR    = 2'd2,
    DR_USR    = 2'd3
  } dr_sel_e;

  localparam int unsigned OP_IDCODE  = 32'd1;
  localparam int unsigned OP_SAMPLE  = 32'd2;
  localparam int unsigned OP_PRELOAD = 32'd3;
  localparam int unsigned OP_INTEST  = 32'd4;
  localparam int unsigned OP_EXTEST  = 32'd5;
  localparam int unsigned USER_BASE  = 32'd8;

  // Low two bits loaded into the IR on Capture-IR; upper bits are zero.
  localparam logic [1:0] IR_CAPTURE_LSBS = 2'b01;

  function automatic int unsigned bypass_opcode(input int unsigned ir_w);
    return (32'd1 << ir_w) - 32'd1;
  endfunction

endpackage

// File: rtl/jtag_tap_param_if.sv
// Board-side JTAG serial pins of the TAP.
interface jtag_tap_param_if;
  logic tms;
  logic tdi;
  logic tdo;
  logic tdo_en;

  modport master (output tms, output tdi, input tdo, input tdo_en);
  modport slave  (input tms, input tdi, output tdo, output tdo_en);
endinterface

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP state machine with decoded per-state strobes.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       rst_n,
  input  logic       tms,
  output tap_state_e state,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr,
  output logic       tlr
);

  tap_state_e state_r;
  tap_state_e next_s;

  // State register.
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= TAP_TLR;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic; five tms=1 cycles reach TLR from any state.
  always_comb begin
    next_s = state_r;
    case (state_r)
      TAP_TLR:   next_s = tms ? TAP_TLR   : TAP_RTI;
      TAP_RTI:   next_s = tms ? TAP_SELDR : TAP_RTI;
      TAP_SELDR: next_s = tms ? TAP_SELIR : TAP_CAPDR;
      TAP_CAPDR: next_s = tms ? TAP_EX1DR : TAP_SHDR;
      TAP_SHDR:  next_s = tms ? TAP_EX1DR : TAP_SHDR;
      TAP_EX1DR: next_s = tms ? TAP_UPDDR : TAP_PAUDR;
      TAP_PAUDR: next_s = tms ? TAP_EX2DR : TAP_PAUDR;
      TAP_EX2DR: next_s = tms ? TAP_UPDDR : TAP_SHDR;
      TAP_UPDDR: next_s = tms ? TAP_SELDR : TAP_RTI;
      TAP_SELIR: next_s = tms ? TAP_TLR   : TAP_CAPIR;
      TAP_CAPIR: next_s = tms ? TAP_EX1IR : TAP_SHIR;
      TAP_SHIR:  next_s = tms ? TAP_EX1IR : TAP_SHIR;
      TAP_EX1IR: next_s = tms ? TAP_UPDIR : TAP_PAUIR;
      TAP_PAUIR: next_s = tms ? TAP_EX2IR : TAP_PAUIR;
      TAP_EX2IR: next_s = tms ? TAP_UPDIR : TAP_SHIR;
      TAP_UPDIR: next_s = tms ? TAP_SELDR : TAP_RTI;
      default:   next_s = TAP_TLR;
    endcase
  end

  // State-decoded strobes.
  always_comb begin
    capture_ir = (state_r == TAP_CAPIR);
    shift_ir   = (state_r == TAP_SHIR);
    update_ir  = (state_r == TAP_UPDIR);
    capture_dr = (state_r == TAP_CAPDR);
    shift_dr   = (state_r == TAP_SHDR);
    update_dr  = (state_r == TAP_UPDDR);
    tlr        = (state_r == TAP_TLR);
  end

  assign state = state_r;

endmodule

// File: rtl/jtag_tap_param.sv
// Parametrised JTAG TAP: IR, BYPASS, IDCODE, boundary scan and N_USR user DR channels.
module jtag_tap_param
  import jtag_pkg::*;
#(
  parameter int unsigned IR_W   = 5,
  parameter logic [31:0] IDCODE = 32'hdeadbeef,
  parameter int unsigned BSR_W  = 7,
  parameter int unsigned N_USR  = 2,
  parameter int unsigned USR_W  = 8
) (
  input  logic                     tck,
  input  logic                     rst_n,
  jtag_tap_param_if.slave          jtag,
  input  logic [BSR_W-1:0]         bsr_pins_in,
  output logic [BSR_W-1:0]         bsr_out,
  output logic                     bsr_drive,
  input  logic [N_USR*USR_W-1:0]   usr_capture_data,
  output logic [USR_W-1:0]         usr_update_data,
  output logic [N_USR-1:0]         usr_update_vld,
  output logic [N_USR-1:0]         usr_capture_vld,
  output logic [3:0]               state_o
);

  localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(IR_CAPTURE_LSBS);
  localparam logic [IR_W-1:0] IR_RESET   = IR_W'(OP_IDCODE);

  tap_state_e state_s;
  logic capture_ir_s, shift_ir_s, update_ir_s;
  logic capture_dr_s, shift_dr_s, update_dr_s, tlr_s;

  logic [IR_W-1:0]  ir_shift_r;
  logic [IR_W-1:0]  ir_active_r;
  logic             bypass_r;
  logic [31:0]      id_r;
  logic [BSR_W-1:0] bsr_shift_r;
  logic [BSR_W-1:0] bsr_out_r;
  logic [USR_W-1:0] usr_shift_r [N_USR];
  logic [USR_W-1:0] usr_upd_data_r;
  logic [N_USR-1:0] usr_upd_vld_r;
  logic [N_USR-1:0] usr_cap_vld_s;
  logic             tdo_r;
  logic             tdo_en_r;
  logic             bsr_drive_r;
  logic             tdo_bit_s;
  dr_sel_e          dr_sel_s;
  int unsigned      usr_idx_s;

  function automatic dr_sel_e decode_dr(input logic [IR_W-1:0] op);
    int unsigned v;
    v = 32'(op);
    if (v == bypass_opcode(IR_W))                          return DR_BYPASS;
    else if (v == OP_IDCODE)                               return DR_ID;
    else if (v >= OP_SAMPLE && v <= OP_EXTEST)             return DR_BSR;
    else if (v >= USER_BASE && v < USER_BASE + N_USR)      return DR_USR;
    else                                                   return DR_BYPASS;
  endfunction

  function automatic logic is_drive_op(input logic [IR_W-1:0] op);
    int unsigned v;
    v = 32'(op);
    return (v != bypass_opcode(IR_W)) && (v == OP_INTEST || v == OP_EXTEST);
  endfunction

  jtag_tap_fsm u_fsm (
    .tck        (tck),
    .rst_n      (rst_n),
    .tms        (jtag.tms),
    .state      (state_s),
    .capture_ir (capture_ir_s),
    .shift_ir   (shift_ir_s),
    .update_ir  (update_ir_s),
    .capture_dr (capture_dr_s),
    .shift_dr   (shift_dr_s),
    .update_dr  (update_dr_s),
    .tlr        (tlr_s)
  );

  // Instruction decode and capture-valid strobes.
  always_comb begin
    dr_sel_s      = decode_dr(ir_active_r);
    usr_idx_s     = 32'(ir_active_r) - USER_BASE;
    usr_cap_vld_s = {N_USR{1'b0}};
    for (int unsigned k = 0; k < N_USR; k++) begin
      if (capture_dr_s && dr_sel_s == DR_USR && usr_idx_s == k) begin
        usr_cap_vld_s[k] = 1'b1;
      end else begin
        usr_cap_vld_s[k] = 1'b0;
      end
    end
  end

  // Serial output mux: LSB of the register currently in the scan path.
  always_comb begin
    tdo_bit_s = 1'b0;
    if (shift_ir_s) begin
      tdo_bit_s = ir_shift_r[0];
    end else begin
      case (dr_sel_s)
        DR_ID:  tdo_bit_s = id_r[0];
        DR_BSR: tdo_bit_s = bsr_shift_r[0];
        DR_USR: begin
          for (int unsigned k = 0; k < N_USR; k++) begin
            if (usr_idx_s == k) begin
              tdo_bit_s = usr_shift_r[k][0];
            end else begin
              tdo_bit_s = tdo_bit_s;
            end
          end
        end
        default: tdo_bit_s = bypass_r;
      endcase
    end
  end

  // Capture/shift of IR and the selected DR; TLR deliberately leaves these alone.
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      ir_shift_r  <= {IR_W{1'b0}};
      bypass_r    <= 1'b0;
      id_r        <= IDCODE;
      bsr_shift_r <= {BSR_W{1'b0}};
      for (int unsigned k = 0; k < N_USR; k++) begin
        usr_shift_r[k] <= {USR_W{1'b0}};
      end
    end else begin
      if (capture_ir_s) begin
        ir_shift_r <= IR_CAPTURE;
      end else if (shift_ir_s) begin
        ir_shift_r <= {jtag.tdi, ir_shift_r[IR_W-1:1]};
      end
      if (capture_dr_s) begin
        case (dr_sel_s)
          DR_ID:  id_r        <= IDCODE;
          DR_BSR: bsr_shift_r <= is_drive_op(ir_active_r) && (32'(ir_active_r) == OP_INTEST)
                                 ? bsr_out_r : bsr_pins_in;
          DR_USR: begin
            for (int unsigned k = 0; k < N_USR; k++) begin
              if (usr_idx_s == k) usr_shift_r[k] <= usr_capture_data[k*USR_W +: USR_W];
            end
          end
          default: bypass_r <= 1'b0;
        endcase
      end else if (shift_dr_s) begin
        case (dr_sel_s)
          DR_ID:  id_r        <= {jtag.tdi, id_r[31:1]};
          DR_BSR: bsr_shift_r <= {jtag.tdi, bsr_shift_r[BSR_W-1:1]};
          DR_USR: begin
            for (int unsigned k = 0; k < N_USR; k++) begin
              if (usr_idx_s == k) usr_shift_r[k] <= {jtag.tdi, usr_shift_r[k][USR_W-1:1]};
            end
          end
          default: bypass_r <= jtag.tdi;
        endcase
      end
    end
  end

  // Negedge side: tdo, instruction/update registers and update pulses.
  always_ff @(negedge tck or negedge rst_n) begin
    if (!rst_n) begin
      ir_active_r    <= IR_RESET;
      tdo_r          <= 1'b0;
      tdo_en_r       <= 1'b0;
      bsr_out_r      <= {BSR_W{1'b0}};
      bsr_drive_r    <= 1'b0;
      usr_upd_data_r <= {USR_W{1'b0}};
      usr_upd_vld_r  <= {N_USR{1'b0}};
    end else if (tlr_s) begin
      ir_active_r    <= IR_RESET;
      tdo_r          <= 1'b0;
      tdo_en_r       <= 1'b0;
      bsr_out_r      <= {BSR_W{1'b0}};
      bsr_drive_r    <= 1'b0;
      usr_upd_data_r <= {USR_W{1'b0}};
      usr_upd_vld_r  <= {N_USR{1'b0}};
    end else begin
      tdo_en_r      <= shift_ir_s | shift_dr_s;
      usr_upd_vld_r <= {N_USR{1'b0}};
      if (shift_ir_s || shift_dr_s) tdo_r <= tdo_bit_s;
      if (update_ir_s) begin
        ir_active_r <= ir_shift_r;
        bsr_drive_r <= is_drive_op(ir_shift_r);
      end
      if (update_dr_s) begin
        case (dr_sel_s)
          DR_BSR: bsr_out_r <= bsr_shift_r;
          DR_USR: begin
            for (int unsigned k = 0; k < N_USR; k++) begin
              if (usr_idx_s == k) begin
                usr_upd_data_r   <= usr_shift_r[k];
                usr_upd_vld_r[k] <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign jtag.tdo        = tdo_r;
  assign jtag.tdo_en     = tdo_en_r;
  assign bsr_out         = bsr_out_r;
  assign bsr_drive       = bsr_drive_r;
  assign usr_update_data = usr_upd_data_r;
  assign usr_update_vld  = usr_upd_vld_r;
  assign usr_capture_vld = usr_cap_vld_s;
  assign state_o         = state_s;

endmodule
